// File: rtl/stencil_pkg.sv
// Shared defaults and elaboration helpers for the stencil window-sum stream.
// Holds counter-width and parameter legality functions used by all stencil files.
package stencil_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;
    localparam int DEF_K     = 3;

    localparam int K_MIN   = 3;
    localparam int K_MAX   = 7;
    localparam int DIM_MIN = 4;
    localparam int DIM_MAX = 1024;

    // Bits needed to count 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Only odd kernel edges 3, 5 and 7 are supported.
    function automatic bit k_legal(input int k);
        return (k >= K_MIN) && (k <= K_MAX) && ((k % 2) == 1);
    endfunction

    function automatic bit dim_legal(input int n);
        return (n >= DIM_MIN) && (n <= DIM_MAX);
    endfunction

endpackage

// File: rtl/stencil_line_row.sv
// One image-row delay line: DEPTH entries of WIDTH bits, addressed by column.
// Ports: clk, i_en (write strobe), i_addr (column), i_data (in), o_data (same column, one row earlier).
module stencil_line_row
    import stencil_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_IMG_W,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Contents are deliberately unreset; valid flags elsewhere mask stale data.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Read-before-write at the same column yields exactly one row of delay.
    assign o_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_data;
        end
    end

endmodule

// File: rtl/stencil_sum_stream.sv
// Streaming K x K window sum over a raster image (valid convolution, no padding).
// Ports: clk, reset, in_valid/in_data/in_ready (pixel in), out_valid/out_data/out_ready (sum out), frame_done.
module stencil_sum_stream
    import stencil_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             frame_done
);

    if (!k_legal(K)) begin : g_bad_k
        $fatal(1, "stencil_sum_stream: K must be odd and within 3..7");
    end

    if (!dim_legal(IMG_W) || !dim_legal(IMG_H)) begin : g_bad_dim
        $fatal(1, "stencil_sum_stream: IMG_W/IMG_H must be within 4..1024");
    end

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] WIN_COL  = CW'(K - 1);
    localparam logic [RW-1:0] WIN_ROW  = RW'(K - 1);

    logic             w_en;
    logic             w_accept;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_win_ok;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_col_vec [K];

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_s1_valid;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_frame_done;
    logic [WIDTH-1:0] r_win [K][K];

    // A single enable stalls the whole pipeline when the output is blocked.
    assign w_en       = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_en;
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);
    assign w_win_ok   = (r_col >= WIN_COL) && (r_row >= WIN_ROW);

    assign in_ready   = w_en;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;

    // Column vector entry j holds the pixel j rows above the current one.
    assign w_col_vec[0] = in_data;

    for (genvar j = 1; j < K; j++) begin : g_rows
        stencil_line_row #(
            .WIDTH (WIDTH),
            .DEPTH (IMG_W),
            .AW    (CW)
        ) u_row (
            .clk    (clk),
            .i_en   (w_accept),
            .i_addr (r_col),
            .i_data (w_col_vec[j-1]),
            .o_data (w_col_vec[j])
        );
    end

    // Window columns shift only on accept, so input bubbles leave it intact.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = K - 1; k > 0; k--) begin
                for (int j = 0; j < K; j++) begin
                    r_win[k][j] <= r_win[k-1][j];
                end
            end
            for (int j = 0; j < K; j++) begin
                r_win[0][j] <= w_col_vec[j];
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < K; k++) begin
            for (int j = 0; j < K; j++) begin
                w_sum = w_sum + r_win[k][j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last_col && w_last_row;
            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_en) begin
                r_s1_valid  <= w_accept && w_win_ok;
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_sum;
                end
            end
        end
    end

endmodule
